uart_rx_core: RTL

Parametrised UART receive core for the serial front end. It synchronises the asynchronous `rx` line into the `clk` domain and detects a start bit with a mid-bit false-start check. It then samples a configurable frame (data bits, optional parity, 1 or 2 stop bits) at bit centres, using a baud divider derived from `clk`. Each completed frame is delivered as a one-cycle `data_valid` strobe with parity and framing status, and the current state is exported as a one-hot bus for debug and downstream sequencing.

---
 rtl/uart_rx_core.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// UART receive core: 2-flop input synchroniser, mid-bit start validation and
// centre sampling of data, optional parity and 1-2 stop bits.
//
// state  | meaning
// IDLE   | line idle; waiting for a low rxs while armed
// START  | counting to the start-bit centre to reject glitches
// DATA   | sampling data bits LSB first at bit centres
// PARITY | sampling the parity bit and computing perr
// STOP   | sampling stop bits; delivers the frame after the last one
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [4:0]           state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1    = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 rx_meta;
  logic                 rxs;
  logic                 armed;
  logic                 ferr;
  logic                 perr;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 mid_tick;
  logic                 end_tick;
  logic                 done;

  assign mid_tick = (bit_cnt == HALF_M1);
  assign end_tick = (bit_cnt == BIT_M1);
  assign done     = (state_q == STOP) && end_tick && (idx == LAST_STOP);
  assign busy     = (state_q != IDLE);
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!rxs && armed) state_d = START;
      START:  if (mid_tick) state_d = rxs ? IDLE : DATA;
      DATA:   if (end_tick && idx == LAST_DATA) state_d = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY: if (end_tick) state_d = STOP;
      STOP:   if (end_tick && idx == LAST_STOP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      state_q    <= IDLE;
      bit_cnt    <= '0;
      idx        <= '0;
      armed      <= 1'b1;
      ferr       <= 1'b0;
      perr       <= 1'b0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rxs        <= rx_meta;
      state_q    <= state_d;
      data_valid <= done;

      // bit_cnt wraps explicitly so non-power-of-two bit periods work
      if (state_d != state_q || state_q == IDLE || end_tick) bit_cnt <= '0;
      else bit_cnt <= bit_cnt + CW'(1);

      // a frame ending in a framing error disarms until the line goes high (break)
      if (done && (ferr || !rxs)) armed <= 1'b0;
      else if (rxs) armed <= 1'b1;

      if (state_q != START && state_d == START) begin
        ferr <= 1'b0;
        perr <= 1'b0;
      end

      case (state_q)
        START: if (mid_tick) idx <= '0;
        DATA: if (end_tick) begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (idx == IW'(i)) shreg[i] <= rxs;
          end
          idx <= (idx == LAST_DATA) ? '0 : idx + IW'(1);
        end
        PARITY: if (end_tick) begin
          perr <= (^shreg) ^ rxs ^ (PARITY_MODE == 1);
          idx  <= '0;
        end
        STOP: if (end_tick) begin
          if (!rxs) ferr <= 1'b1;
          if (idx == LAST_STOP) begin
            data_out   <= shreg;
            parity_err <= perr;
            frame_err  <= ferr | !rxs;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
